// File: rtl/k16_panel_scan_pkg.sv
// Shared constants for the front-panel scanner and the I/O register block:
// nibble/group geometry, group indices and control-switch bit positions.
package k16_panel_scan_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned GRP_W = 3;
  localparam int unsigned N_GRP = 8;
  localparam int unsigned BUS_W = 16;
  localparam int unsigned CNT_W = 3;

  localparam logic [GRP_W-1:0] ADDR_GRP0 = 3'd0;
  localparam logic [GRP_W-1:0] ADDR_GRP1 = 3'd1;
  localparam logic [GRP_W-1:0] ADDR_GRP2 = 3'd2;
  localparam logic [GRP_W-1:0] ADDR_GRP3 = 3'd3;
  localparam logic [GRP_W-1:0] CTRL_GRP0 = 3'd4;
  localparam logic [GRP_W-1:0] CTRL_GRP1 = 3'd5;
  localparam logic [GRP_W-1:0] CTRL_GRP2 = 3'd6;
  localparam logic [GRP_W-1:0] CTRL_GRP3 = 3'd7;

  // Bit positions within ctrl_switches / ctrl_pulse
  localparam int unsigned EXAMINE      = 0;
  localparam int unsigned DEPOSIT      = 1;
  localparam int unsigned STOP         = 2;
  localparam int unsigned RESET        = 3;
  localparam int unsigned CONTINUE     = 4;
  localparam int unsigned START        = 5;
  localparam int unsigned DEPOSIT_NEXT = 6;
  localparam int unsigned EXAMINE_NEXT = 7;
  localparam int unsigned INST_STEP    = 8;

  // Select nibble idx of a 16-bit bus
  function automatic logic [NIB_W-1:0] grp_nibble(input logic [BUS_W-1:0] bus,
                                                  input logic [1:0]       idx);
    return bus[{idx, 2'b00} +: NIB_W];
  endfunction

endpackage

// File: rtl/k16_panel_scan_if.sv
// Panel-side signal bundle: LED sources and raw switches in, scan strobes and
// debounced switch state out.
interface k16_panel_scan_if;
  import k16_panel_scan_pkg::*;

  logic [BUS_W-1:0] addr_leds;
  logic [BUS_W-1:0] data_leds;
  logic [NIB_W-1:0] io_switches;
  logic [GRP_W-1:0] io_addr;
  logic [NIB_W-1:0] io_leds;
  logic [BUS_W-1:0] addr_switches;
  logic [BUS_W-1:0] ctrl_switches;
  logic [BUS_W-1:0] ctrl_pulse;
  logic             frame_done;

  modport master (
    output addr_leds, data_leds, io_switches,
    input  io_addr, io_leds, addr_switches, ctrl_switches, ctrl_pulse, frame_done
  );

  modport slave (
    input  addr_leds, data_leds, io_switches,
    output io_addr, io_leds, addr_switches, ctrl_switches, ctrl_pulse, frame_done
  );
endinterface

// File: rtl/k16_nibble_debounce.sv
// Debounces one 4-bit switch group: the output follows a sample only after
// DEBOUNCE_SCANS consecutive identical samples.
module k16_nibble_debounce
  import k16_panel_scan_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_en_i,
  input  logic [NIB_W-1:0] sample_i,
  output logic [NIB_W-1:0] deb_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [NIB_W-1:0] held_q, held_d;
  logic [NIB_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A differing sample restarts the run; the run length saturates at CNT_MAX
  always_comb begin
    held_d = held_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (sample_en_i) begin
      if (sample_i != held_q) begin
        held_d = sample_i;
        cnt_d  = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CNT_MAX) begin
        deb_d = sample_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_q <= '0;
      cnt_q  <= '0;
      deb_q  <= '0;
    end else begin
      held_q <= held_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/k16_panel_scan.sv
// Front-panel scanner: walks 8 LED/switch groups, one per slot, drives the LED
// nibble for the active group and debounces the switch nibble read back.
module k16_panel_scan
  import k16_panel_scan_pkg::*;
#(
  parameter int unsigned SLOT_DIV       = 62500,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  k16_panel_scan_if.slave   pnl
);

  localparam int unsigned       SLOT_W    = $clog2(SLOT_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_DIV - 1);
  localparam int unsigned       HALF_GRP  = N_GRP / 2;

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [GRP_W-1:0]  grp_q, grp_d;
  logic [NIB_W-1:0]  leds_q, leds_d;
  logic [NIB_W-1:0]  sync1_q, sync2_q;
  logic              frame_done_q, frame_done_d;
  logic [BUS_W-1:0]  ctrl_prev_q;
  logic [BUS_W-1:0]  pulse_q, pulse_d;

  logic              slot_end_c;
  logic [NIB_W-1:0]  sample_c;
  logic [N_GRP-1:0]  sample_en_c;
  logic [BUS_W-1:0]  addr_sw_c;
  logic [BUS_W-1:0]  ctrl_sw_c;

  assign slot_end_c = (slot_q == SLOT_LAST);

  // Slot timing, LED nibble for the upcoming group, switch polarity, pulses
  always_comb begin
    slot_d       = slot_q + 1'b1;
    grp_d        = grp_q;
    leds_d       = leds_q;
    frame_done_d = 1'b0;
    sample_c     = (grp_q >= CTRL_GRP0) ? ~sync2_q : sync2_q;
    pulse_d      = ctrl_sw_c & ~ctrl_prev_q;
    if (slot_end_c) begin
      slot_d       = '0;
      grp_d        = grp_q + 1'b1;
      leds_d       = grp_d[GRP_W-1] ? grp_nibble(pnl.data_leds, grp_d[1:0])
                                    : grp_nibble(pnl.addr_leds, grp_d[1:0]);
      frame_done_d = (grp_q == CTRL_GRP3);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q       <= '0;
      grp_q        <= '0;
      leds_q       <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      frame_done_q <= 1'b0;
      ctrl_prev_q  <= '0;
      pulse_q      <= '0;
    end else begin
      slot_q       <= slot_d;
      grp_q        <= grp_d;
      leds_q       <= leds_d;
      sync1_q      <= pnl.io_switches;
      sync2_q      <= sync1_q;
      frame_done_q <= frame_done_d;
      ctrl_prev_q  <= ctrl_sw_c;
      pulse_q      <= pulse_d;
    end
  end

  for (genvar g = 0; g < N_GRP; g++) begin : g_grp
    logic [NIB_W-1:0] deb;

    assign sample_en_c[g] = slot_end_c && (grp_q == GRP_W'(g));

    k16_nibble_debounce #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_deb (
      .clk         (clk),
      .reset_n     (reset_n),
      .sample_en_i (sample_en_c[g]),
      .sample_i    (sample_c),
      .deb_o       (deb)
    );

    if (g < HALF_GRP) begin : g_addr
      assign addr_sw_c[g*NIB_W +: NIB_W] = deb;
    end else begin : g_ctrl
      assign ctrl_sw_c[(g-HALF_GRP)*NIB_W +: NIB_W] = deb;
    end
  end

  assign pnl.io_addr       = grp_q;
  assign pnl.io_leds       = leds_q;
  assign pnl.addr_switches = addr_sw_c;
  assign pnl.ctrl_switches = ctrl_sw_c;
  assign pnl.ctrl_pulse    = pulse_q;
  assign pnl.frame_done    = frame_done_q;

endmodule

// File: tb/tb_k16_panel_scan.sv
// Directed bench for k16_panel_scan with SLOT_DIV=8, DEBOUNCE_SCANS=3.
module tb_k16_panel_scan;

  localparam int unsigned SLOT_DIV = 8;
  localparam int unsigned DEB      = 3;

  logic clk = 1'b0;
  logic reset_n;

  k16_panel_scan_if pnl ();

  k16_panel_scan #(
    .SLOT_DIV       (SLOT_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pnl     (pnl)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cyc  = 0;
  int pl_cyc  = 0;

  always @(negedge clk) begin
    if (pnl.frame_done === 1'b1) fd_cyc <= fd_cyc + 1;
    if (pnl.ctrl_pulse !== 16'h0000) pl_cyc <= pl_cyc + 1;
  end

  typedef struct {
    logic [2:0] grp;
    logic [3:0] led;
  } led_vec_t;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] exp_nib;
  } deb_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to the start of the next slot (io_addr change), bounded
  task automatic next_slot(output int len);
    logic [2:0] prev;
    prev = pnl.io_addr;
    len  = 0;
    do begin
      @(negedge clk);
      len++;
    end while (pnl.io_addr == prev && len < 40);
  endtask

  task automatic run_slots(input int n);
    int len;
    for (int i = 0; i < n; i++) next_slot(len);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    led_vec_t lv[8];
    deb_vec_t dv[6];
    int len;
    int base;
    int idx;

    lv[0] = '{3'd0, 4'h4}; lv[1] = '{3'd1, 4'h3};
    lv[2] = '{3'd2, 4'h2}; lv[3] = '{3'd3, 4'h1};
    lv[4] = '{3'd4, 4'hD}; lv[5] = '{3'd5, 4'hC};
    lv[6] = '{3'd6, 4'hB}; lv[7] = '{3'd7, 4'hA};

    dv[0] = '{4'h5, 4'h0}; dv[1] = '{4'h5, 4'h0};
    dv[2] = '{4'hA, 4'h0}; dv[3] = '{4'h5, 4'h0};
    dv[4] = '{4'h5, 4'h0}; dv[5] = '{4'h5, 4'h5};

    // Reset values
    reset_n         = 1'b0;
    pnl.addr_leds   = 16'h1234;
    pnl.data_leds   = 16'hABCD;
    pnl.io_switches = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_io_addr",  32'(pnl.io_addr), 32'h0);
    check("rst_io_leds",  32'(pnl.io_leds), 32'h0);
    check("rst_addr_sw",  32'(pnl.addr_switches), 32'h0);
    check("rst_ctrl_sw",  32'(pnl.ctrl_switches), 32'h0);
    check("rst_pulse",    32'(pnl.ctrl_pulse), 32'h0);
    check("rst_frame_dn", 32'(pnl.frame_done), 32'h0);

    // Scan order, slot length, LED nibbles, frame_done, all-F debounce
    reset_n = 1'b1;
    base = fd_cyc;
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 8; s++) begin
        idx = (s + 1) % 8;
        next_slot(len);
        check("slot_len", 32'(len), 32'd8);
        check("io_addr", 32'(pnl.io_addr), 32'(lv[idx].grp));
        check("io_leds", 32'(pnl.io_leds), 32'(lv[idx].led));
        check("frame_done_at_slot", 32'(pnl.frame_done), (idx == 0) ? 32'h1 : 32'h0);
      end
      if (f == 1) begin
        check("addr_sw_after_2_frames", 32'(pnl.addr_switches), 32'h0000);
      end
    end
    check("addr_sw_after_3_frames", 32'(pnl.addr_switches), 32'hFFFF);
    check("ctrl_sw_after_3_frames", 32'(pnl.ctrl_switches), 32'h0000);
    @(negedge clk);
    #1;
    check("frame_done_cycles", 32'(fd_cyc - base), 32'd3);

    // Group 4 pressed from frame 1 to 4, then released
    pnl.io_switches = 4'hF;
    do_reset();
    base = pl_cyc;
    for (int f = 0; f < 8; f++) begin
      for (int s = 0; s < 8; s++) begin
        pnl.io_switches = (s == 4 && f >= 1 && f <= 4) ? 4'hE : 4'hF;
        next_slot(len);
        if (s == 4) begin
          check("ctrl_sw_grp4", 32'(pnl.ctrl_switches),
                (f >= 3 && f <= 6) ? 32'h0001 : 32'h0000);
          if (f == 3) begin
            check("pulse_same_cycle", 32'(pnl.ctrl_pulse), 32'h0000);
            @(negedge clk);
            check("pulse_next_cycle", 32'(pnl.ctrl_pulse), 32'h0001);
          end
        end
      end
    end
    @(negedge clk);
    #1;
    check("pulse_total_cycles", 32'(pl_cyc - base), 32'd1);

    // Glitch on group 0: 5,5,A,5,5,5
    pnl.io_switches = dv[0].sw;
    do_reset();
    for (int f = 0; f < 6; f++) begin
      pnl.io_switches = dv[f].sw;
      next_slot(len);
      check("grp0_debounce", 32'(pnl.addr_switches[3:0]), 32'(dv[f].exp_nib));
      pnl.io_switches = 4'hF;
      run_slots(7);
    end

    // Asynchronous reset mid-frame discards debounce progress
    pnl.io_switches = 4'hF;
    do_reset();
    run_slots(19);
    repeat (3) @(negedge clk);
    check("pre_rst_io_addr", 32'(pnl.io_addr), 32'h3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_io_addr", 32'(pnl.io_addr), 32'h0);
    check("async_rst_io_leds", 32'(pnl.io_leds), 32'h0);
    check("async_rst_addr_sw", 32'(pnl.addr_switches), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    next_slot(len);
    check("post_rst_first_slot_len", 32'(len), 32'd8);
    check("post_rst_first_grp", 32'(pnl.io_addr), 32'h1);
    run_slots(15);
    check("post_rst_2_frames", 32'(pnl.addr_switches), 32'h0000);
    run_slots(8);
    check("post_rst_3_frames", 32'(pnl.addr_switches), 32'hFFFF);
    check("post_rst_ctrl", 32'(pnl.ctrl_switches), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
